// File: rtl/alu_mdu_if.sv
// alu_mdu request/result handshake bundle.
// Producer side is master; the execution unit is slave.
interface alu_mdu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/alu_mdu.sv
// Execute-stage ALU with iterative RV32M multiply/divide.
// Base ops and divide corner cases finish in one cycle.
module alu_mdu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input logic      clk,
  input logic      rst,
  alu_mdu_if.slave bus
);

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_LT  = 4'd8;
  localparam logic [3:0] ALU_LTU = 4'd9;

  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_t;

  state_t            state_q, state_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        mop_q, mop_d;
  logic              neg_q, neg_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0] a, b;
  logic [4:0]      op;
  logic [2:0]      mf;
  logic            is_m, is_mul, is_div;
  logic            sa, sb, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            b_zero, ovf, div_spec;
  logic [XLEN-1:0] spec_res, alu_res;
  logic            in_ready, accept;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt, mul_prod;
  logic [XLEN:0]     div_try, div_diff;
  logic [2*XLEN-1:0] div_nxt;
  logic [XLEN-1:0]   div_val, div_res;

  assign a      = bus.a;
  assign b      = bus.b;
  assign op     = bus.op;
  assign mf     = op[2:0];
  assign is_m   = op[4];
  assign is_mul = is_m && !mf[2];
  assign is_div = is_m && mf[2];

  // Operand signedness for the selected M op.
  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    unique case (1'b1)
      mf[2]: begin
        sa = !mf[0];
        sb = !mf[0];
      end
      mf == 3'd1: begin
        sa = 1'b1;
        sb = 1'b1;
      end
      mf == 3'd2: sa = 1'b1;
      default: ;
    endcase
  end

  assign neg_a = sa && a[XLEN-1];
  assign neg_b = sb && b[XLEN-1];
  assign mag_a = neg_a ? -a : a;
  assign mag_b = neg_b ? -b : b;

  assign b_zero   = (b == '0);
  assign ovf      = is_div && sa &&
                    (a == MIN_NEG) && (b == '1);
  assign div_spec = is_div && (b_zero || ovf);
  assign spec_res = b_zero ? (mf[1] ? a : '1)
                           : (mf[1] ? '0 : a);

  // Single-cycle base ALU; unknown codes give zero.
  always_comb begin
    alu_res = '0;
    case (op[3:0])
      ALU_ADD: alu_res = a + b;
      ALU_SUB: alu_res = a - b;
      ALU_AND: alu_res = a & b;
      ALU_OR:  alu_res = a | b;
      ALU_XOR: alu_res = a ^ b;
      ALU_SLL: alu_res = a << b[SHW-1:0];
      ALU_SRL: alu_res = a >> b[SHW-1:0];
      ALU_SRA: alu_res =
        $unsigned($signed(a) >>> b[SHW-1:0]);
      ALU_LT:  alu_res =
        {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_LTU: alu_res =
        {{(XLEN-1){1'b0}}, a < b};
      default: alu_res = '0;
    endcase
  end

  // Shift-add step: hi half accumulates, lo half
  // holds the remaining multiplier bits.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    {1'b0, {XLEN{acc_q[0]}} & opb_q};
  assign mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
  assign mul_prod = neg_q ? -mul_nxt : mul_nxt;

  // Restoring step: hi half is the partial
  // remainder, lo half shifts dividend out and
  // quotient bits in.
  assign div_try  = {acc_q[2*XLEN-1:XLEN],
                     acc_q[XLEN-1]};
  assign div_diff = div_try - {1'b0, opb_q};
  assign div_nxt  = div_diff[XLEN]
    ? {div_try[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign div_val  = mop_q[1]
    ? div_nxt[2*XLEN-1:XLEN]
    : div_nxt[XLEN-1:0];
  assign div_res  = neg_q ? -div_val : div_val;

  assign in_ready = (state_q == IDLE) &&
                    (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Next-state, iteration and result-load logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opb_d       = opb_q;
    mop_d       = mop_q;
    neg_d       = neg_q;
    result_d    = result_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_m || div_spec) begin
            result_d    = is_m ? spec_res : alu_res;
            out_valid_d = 1'b1;
          end else begin
            state_d = is_mul ? MUL : DIV;
            cnt_d   = '0;
            acc_d   = {{XLEN{1'b0}}, mag_a};
            opb_d   = mag_b;
            mop_d   = mf;
            neg_d   = (is_div && mf[1])
                      ? neg_a : (neg_a ^ neg_b);
          end
        end
      end
      MUL: begin
        acc_d = mul_nxt;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == '1) begin
          result_d    = (mop_q == 3'd0)
            ? mul_prod[XLEN-1:0]
            : mul_prod[2*XLEN-1:XLEN];
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      DIV: begin
        acc_d = div_nxt;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == '1) begin
          result_d    = div_res;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opb_q       <= '0;
      mop_q       <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opb_q       <= opb_d;
      mop_q       <= mop_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised execution unit that succeeds the single-cycle combinational ALU. It adds RV32M multiply, divide and remainder, a configurable datapath width, and valid/ready handshakes on both sides. Base ALU operations complete in one cycle. Multiply and divide run iteratively over XLEN cycles. The unit sits in the execute stage, and the pipeline stalls on `in_ready`.

## Interface
- `XLEN`, default 32: datapath width; must be a power of two, at least 8.
- `SHW`, default $clog2(XLEN): shift-amount width, derived; do not override.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  unit can accept a request this cycle.
- `op`  in  5  operation code:
  - `op[4]=0`: base op; `op[3:0]` is an `ALU_*` code from defines.vh.
  - `op[4]=1`: M op; `op[2:0]` is 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
  - `op[3]` is ignored when `op[4]=1`.
- `a`, `b`  in  XLEN  operands, sampled only on an accepted request.
- `out_valid`  out  1  `result` valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  XLEN  registered result.
- `busy`  out  1  an iterative operation is in progress.

## Operation
- Handshake rules:
  - A request is accepted on a rising edge with `in_valid && in_ready`.
  - A result is consumed on a rising edge with `out_valid && out_ready`.
  - `in_ready = (state==IDLE) && (!out_valid || out_ready)`. This is combinational, with no path from `in_valid`.
- States: IDLE, MUL, DIV.
- IDLE behaviour:
  - Base op accepted: the result is computed combinationally and registered, and `out_valid` is set. The state stays IDLE.
  - MUL/MULH/MULHSU/MULHU accepted: go to MUL.
  - DIV/DIVU/REM/REMU accepted: go to DIV, unless a special case below applies.
- Base ops:
  - ADD/SUB/AND/OR/XOR wrap modulo 2^XLEN.
  - SLL/SRL/SRA use `b[SHW-1:0]`; SRA is arithmetic.
  - LT is signed and LTU is unsigned; both produce 0 or 1, zero-extended.
  - Undefined codes produce 0 with normal latency.
- MUL state:
  - Latch |a| and |b| according to signedness. MULH is signed×signed; MULHSU is signed a × unsigned b; MUL and MULHU are unsigned.
  - Run radix-2 shift-add into a 2·XLEN accumulator, one bit per cycle, with an iteration counter counting XLEN cycles.
  - On the final iteration, negate the product if the operand signs differ (signed ops only).
  - MUL takes the low XLEN bits; the other three take the high XLEN bits.
  - Register the result, set `out_valid`, return to IDLE.
- DIV state:
  - Restoring division on magnitudes, XLEN iterations.
  - Signed quotient is negated when the operand signs differ. Signed remainder takes the sign of the dividend.
  - Register the result, set `out_valid`, return to IDLE.
- Divide special cases, decided at accept with 1-cycle latency and no DIV state:
  - `b==0`: DIV/DIVU give all-ones; REM/REMU give `a`.
  - Signed overflow (`a==-2^(XLEN-1)`, `b==-1`): DIV gives `a`; REM gives 0.
- Result holding: `result` and `out_valid` hold until consumed. A new result may be loaded in the same cycle the old one is consumed.
- `busy` is 1 exactly while the state is MUL or DIV.
- `in_valid` is ignored while `in_ready` is 0; the producer must hold its request.

## Timing
- Reset values: state IDLE, `out_valid` 0, `result` 0, `busy` 0, counter 0. `in_ready` is 1 immediately after reset.
- Asserting reset mid-operation aborts the operation with no result.
- Base op or divide special case: accepted at edge N, `out_valid` is 1 after edge N+1.
- MUL/DIV: accepted at edge N, `busy` is 1 after edge N+1 through edge N+XLEN, and `out_valid` is 1 after edge N+XLEN+1. Total latency is XLEN+1 cycles.
- Throughput:
  - Base ops: one per cycle when `out_ready` stays high.
  - M ops: one per XLEN+1 cycles.
- Back-pressure:
  - With `out_valid=1` and `out_ready=0`, `in_ready` is 0 and no new result overwrites the held one.
  - Back-to-back M ops are possible when the previous result is consumed on the same edge the next op is accepted.
- `result` changes only on an edge that sets `out_valid`.

## Test plan
- Reset then back-to-back ADD(5,7), SUB(0,1), SRA(0x80000000,4), with `out_ready=1` -> results 12, 0xFFFFFFFF, 0xF8000000 on consecutive cycles; `in_ready` stays 1.
- MULH(-2,3), MULHU(0xFFFFFFFF,0xFFFFFFFF), MUL(0x10000,0x10000) -> 0xFFFFFFFF, 0xFFFFFFFE, 0; each `out_valid` arrives exactly 33 cycles after accept; `busy` is high for 32 cycles.
- DIV(-7,2) -> 0xFFFFFFFD; REM(-7,2) -> 0xFFFFFFFF; DIVU(7,0) -> 0xFFFFFFFF after 1 cycle; REM(0x80000000,-1) -> 0 after 1 cycle.
- Hold `out_ready=0` for 5 cycles after ADD(1,1) -> `result=2` stable, `out_valid=1`, `in_ready=0` with `in_valid` high; release -> the next request is accepted on the same edge.
- Assert `rst` at cycle 10 of a DIVU -> `busy`, `out_valid` and `result` become 0 immediately; after release, ADD(3,4) -> 7 with 1-cycle latency.
- Instantiate with XLEN=16: MULHSU(0xFFFF,0xFFFF) -> 0xFFFF; DIVU(0xFFFF,3) -> 0x5555 after 17 cycles; SLL(1,b=0x13) uses shift amount 3 -> 8.
